// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for the 5-stage MIPS pipeline registers.
package pipe_types_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef logic [1:0] occ_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle around one pipeline stage.
interface pipe_stage_elastic_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             ready_i;

  // Stage side: consumes the upstream push, produces the downstream payload.
  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o
  );

  // Environment side: drives upstream push and downstream ready.
  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o
  );
endinterface

// File: rtl/pipe_stage_elastic_entry.sv
// One valid+data register slot with clear (to NOP), load and invalidate.
module pipe_entry #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clear,
  input  logic             load,
  input  logic             inval,
  input  logic [WIDTH-1:0] d,
  output logic             v,
  output logic [WIDTH-1:0] q
);

  // Clear beats load beats invalidate; invalidate keeps the stale data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v <= 1'b0;
      q <= NOP_VAL;
    end else if (clear) begin
      v <= 1'b0;
      q <= NOP_VAL;
    end else if (load) begin
      v <= 1'b1;
      q <= d;
    end else if (inval) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: head entry plus optional skid entry,
// valid/ready handshake, legacy EN freeze and flush.
module pipe_stage_elastic
  import pipe_types_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter bit               SKID    = 1'b1,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  EN,
  input  logic                  flush,
  pipe_stage_elastic_if.slave   bus,
  output occ_t                  occ_o
);

  logic             main_v, skid_v;
  logic [WIDTH-1:0] main_d, skid_d, main_din;
  logic             main_load, main_clr, main_inval;
  logic             skid_load, skid_clr, skid_inval;
  logic             ready, in_fire, out_fire;

  // With a skid slot ready depends only on state; without one it looks through to ready_i.
  // nRST gates it so nothing is advertised while the stage is held in reset.
  assign ready    = SKID ? (nRST & EN & ~skid_v)
                         : (nRST & EN & (~main_v | bus.ready_i));
  assign in_fire  = bus.valid_i & ready & ~flush;
  assign out_fire = main_v & bus.ready_i & EN;

  assign bus.ready_o = ready;
  assign bus.valid_o = main_v;
  assign bus.data_o  = main_d;
  assign occ_o       = {1'b0, main_v} + {1'b0, skid_v};

  // Next-state control: flush > freeze > normal FIFO advance.
  always_comb begin
    main_load  = 1'b0;
    main_clr   = 1'b0;
    main_inval = 1'b0;
    skid_load  = 1'b0;
    skid_clr   = 1'b0;
    skid_inval = 1'b0;
    main_din   = bus.data_i;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (EN) begin
      if (!main_v || out_fire) begin
        if (skid_v) begin
          main_load = 1'b1;
          main_din  = skid_d;
          if (in_fire) skid_load  = 1'b1;
          else         skid_inval = 1'b1;
        end else if (in_fire) begin
          main_load = 1'b1;
        end else begin
          main_inval = 1'b1;
        end
      end else if (in_fire) begin
        skid_load = 1'b1;
      end
    end
  end

  pipe_entry #(.WIDTH(WIDTH), .NOP_VAL(NOP_VAL)) u_main (
    .CLK   (CLK),
    .nRST  (nRST),
    .clear (main_clr),
    .load  (main_load),
    .inval (main_inval),
    .d     (main_din),
    .v     (main_v),
    .q     (main_d)
  );

  generate
    if (SKID) begin : g_skid
      pipe_entry #(.WIDTH(WIDTH), .NOP_VAL(NOP_VAL)) u_skid (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (skid_clr),
        .load  (skid_load),
        .inval (skid_inval),
        .d     (bus.data_i),
        .v     (skid_v),
        .q     (skid_d)
      );
    end else begin : g_no_skid
      logic unused_skid_ctl;
      assign skid_v          = 1'b0;
      assign skid_d          = NOP_VAL;
      assign unused_skid_ctl = ^{skid_load, skid_clr, skid_inval};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic, SKID=1 and SKID=0 instances.
module tb_pipe_stage_elastic;
  import pipe_types_pkg::*;

  localparam logic [31:0] A   = 32'hA000_0001;
  localparam logic [31:0] B   = 32'hB000_0002;
  localparam logic [31:0] C   = 32'hC000_0003;
  localparam logic [31:0] NOP = NOP_INSTR;

  logic CLK = 1'b0;
  logic nRST;
  logic en1, fl1, en0, fl0;
  occ_t occ1, occ0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_stage_elastic_if #(.WIDTH(32)) bus1 ();
  pipe_stage_elastic_if #(.WIDTH(32)) bus0 ();

  pipe_stage_elastic #(.WIDTH(32), .SKID(1'b1), .NOP_VAL(NOP)) u_dut (
    .CLK(CLK), .nRST(nRST), .EN(en1), .flush(fl1), .bus(bus1), .occ_o(occ1)
  );

  pipe_stage_elastic #(.WIDTH(32), .SKID(1'b0), .NOP_VAL(NOP)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .EN(en0), .flush(fl0), .bus(bus0), .occ_o(occ0)
  );

  typedef struct {
    logic        en;
    logic        fl;
    logic        vi;
    logic [31:0] d;
    logic        ri;
    logic        exp_rdy;   // ready_o before the edge, with these inputs
    logic        exp_v;     // valid_o after the edge
    logic [31:0] exp_d;     // data_o after the edge
    logic [1:0]  exp_occ;   // occ_o after the edge
  } vec_t;

  vec_t t1[22];
  vec_t t0[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // SKID=1: pass-through, backpressure, flush, freeze
    t1[0]  = '{1,0,1,A,1, 1, 1,A,2'd1};
    t1[1]  = '{1,0,1,B,1, 1, 1,B,2'd1};
    t1[2]  = '{1,0,1,C,1, 1, 1,C,2'd1};
    t1[3]  = '{1,0,0,'x,1, 1, 0,C,2'd0};
    t1[4]  = '{1,0,1,A,0, 1, 1,A,2'd1};
    t1[5]  = '{1,0,1,B,0, 1, 1,A,2'd2};
    t1[6]  = '{1,0,1,C,0, 0, 1,A,2'd2};
    t1[7]  = '{1,0,0,0,1, 0, 1,B,2'd1};
    t1[8]  = '{1,0,0,0,1, 1, 0,B,2'd0};
    t1[9]  = '{1,0,1,A,0, 1, 1,A,2'd1};
    t1[10] = '{1,0,1,B,0, 1, 1,A,2'd2};
    t1[11] = '{1,1,1,C,0, 0, 0,NOP,2'd0};
    t1[12] = '{1,1,1,C,1, 1, 0,NOP,2'd0};
    t1[13] = '{1,0,0,0,0, 1, 0,NOP,2'd0};
    t1[14] = '{1,0,1,A,0, 1, 1,A,2'd1};
    t1[15] = '{0,0,1,B,1, 0, 1,A,2'd1};
    t1[16] = '{0,0,1,B,1, 0, 1,A,2'd1};
    t1[17] = '{0,0,1,B,1, 0, 1,A,2'd1};
    t1[18] = '{1,0,1,B,1, 1, 1,B,2'd1};
    t1[19] = '{1,0,0,0,1, 1, 0,B,2'd0};
    t1[20] = '{1,0,1,A,0, 1, 1,A,2'd1};
    t1[21] = '{0,1,1,B,0, 0, 0,NOP,2'd0};
    // SKID=0: ready_o follows ready_i while full
    t0[0]  = '{1,0,1,A,0, 1, 1,A,2'd1};
    t0[1]  = '{1,0,1,B,0, 0, 1,A,2'd1};
    t0[2]  = '{1,0,1,B,1, 1, 1,B,2'd1};
    t0[3]  = '{1,0,1,C,0, 0, 1,B,2'd1};
    t0[4]  = '{1,0,1,C,1, 1, 1,C,2'd1};
    t0[5]  = '{1,0,1,A,1, 1, 1,A,2'd1};
    t0[6]  = '{1,0,0,0,1, 1, 0,A,2'd0};
    t0[7]  = '{0,0,1,B,1, 0, 0,A,2'd0};
    t0[8]  = '{1,1,1,B,1, 1, 0,NOP,2'd0};

    en1 = 1; fl1 = 0; en0 = 1; fl0 = 0;
    bus1.valid_i = 1; bus1.data_i = 32'hDEAD_BEEF; bus1.ready_i = 0;
    bus0.valid_i = 1; bus0.data_i = 32'hDEAD_BEEF; bus0.ready_i = 0;

    // Reset held for two cycles with a push pending
    nRST = 0;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rst_valid", {31'b0, bus1.valid_o}, 32'd0);
      chk("rst_data",  bus1.data_o, NOP);
      chk("rst_occ",   {30'b0, occ1}, 32'd0);
      chk("rst_ready", {31'b0, bus1.ready_o}, 32'd0);
      chk("rst_ready0", {31'b0, bus0.ready_o}, 32'd0);
      chk("rst_occ0",  {30'b0, occ0}, 32'd0);
    end
    bus0.valid_i = 0;
    bus1.valid_i = 0;
    nRST = 1;

    foreach (t1[i]) begin
      @(negedge CLK);
      en1 = t1[i].en; fl1 = t1[i].fl;
      bus1.valid_i = t1[i].vi; bus1.data_i = t1[i].d; bus1.ready_i = t1[i].ri;
      #1;
      chk($sformatf("s1_ready[%0d]", i), {31'b0, bus1.ready_o}, {31'b0, t1[i].exp_rdy});
      @(posedge CLK); #1;
      chk($sformatf("s1_valid[%0d]", i), {31'b0, bus1.valid_o}, {31'b0, t1[i].exp_v});
      chk($sformatf("s1_data[%0d]", i),  bus1.data_o, t1[i].exp_d);
      chk($sformatf("s1_occ[%0d]", i),   {30'b0, occ1}, {30'b0, t1[i].exp_occ});
    end

    // Reset mid-transfer with both entries occupied
    @(negedge CLK);
    en1 = 1; fl1 = 0; bus1.ready_i = 0; bus1.valid_i = 1; bus1.data_i = A;
    @(negedge CLK);
    bus1.data_i = B;
    @(negedge CLK);
    chk("mid_occ_full", {30'b0, occ1}, 32'd2);
    bus1.data_i = C;
    #2 nRST = 0;
    #1;
    chk("mid_rst_valid", {31'b0, bus1.valid_o}, 32'd0);
    chk("mid_rst_data",  bus1.data_o, NOP);
    chk("mid_rst_occ",   {30'b0, occ1}, 32'd0);
    bus1.valid_i = 0;
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK); #1;
    chk("post_rst_valid", {31'b0, bus1.valid_o}, 32'd0);
    chk("post_rst_occ",   {30'b0, occ1}, 32'd0);

    foreach (t0[i]) begin
      @(negedge CLK);
      en0 = t0[i].en; fl0 = t0[i].fl;
      bus0.valid_i = t0[i].vi; bus0.data_i = t0[i].d; bus0.ready_i = t0[i].ri;
      #1;
      chk($sformatf("s0_ready[%0d]", i), {31'b0, bus0.ready_o}, {31'b0, t0[i].exp_rdy});
      @(posedge CLK); #1;
      chk($sformatf("s0_valid[%0d]", i), {31'b0, bus0.valid_o}, {31'b0, t0[i].exp_v});
      chk($sformatf("s0_data[%0d]", i),  bus0.data_o, t0[i].exp_d);
      chk($sformatf("s0_occ[%0d]", i),   {30'b0, occ0}, {30'b0, t0[i].exp_occ});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
